// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array feed path: element width,
// the +0.0 padding pattern and the input skewer state encoding.
package systolic_pkg;

    localparam int DATA_W = 64;
    localparam logic [DATA_W-1:0] ZERO_DATA = 64'h0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        FLUSH = 2'd2
    } skew_state_e;

endpackage

// File: rtl/skew_delay_line.sv
// DEPTH-stage data+valid shift register; stage 0 registers the input, the
// last stage drives the outputs. Synchronous active-low clear.
module skew_delay_line #(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o
);

    logic [DEPTH-1:0][DATA_W-1:0] data_q;
    logic [DEPTH-1:0]             valid_q;

    // Shift chain: every stage advances each cycle, clear wipes in-flight operands
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            data_q  <= '0;
            valid_q <= '0;
        end else begin
            data_q[0]  <= data_i;
            valid_q[0] <= valid_i;
            for (int k = 1; k < DEPTH; k++) begin
                data_q[k]  <= data_q[k-1];
                valid_q[k] <= valid_q[k-1];
            end
        end
    end

    assign data_o  = data_q[DEPTH-1];
    assign valid_o = valid_q[DEPTH-1];

endmodule

// File: rtl/systolic_input_skewer.sv
// Feeds the PE array's left edge: lane i of each accepted row vector is delayed
// by i extra cycles, idle slots carry +0.0 with valid low, done marks burst end.
module systolic_input_skewer #(
    parameter int N      = 4,
    parameter int DATA_W = systolic_pkg::DATA_W,
    parameter int LEN_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [LEN_W-1:0]    len,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*DATA_W-1:0] in_data,
    output logic [N*DATA_W-1:0] out_data,
    output logic [N-1:0]        out_lane_valid,
    output logic                busy,
    output logic                done
);

    import systolic_pkg::*;

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(N - 1);
    localparam bit SINGLE_LANE = (N == 1);

    skew_state_e      state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             done_q, done_d;
    logic             accept_s;

    assign in_ready = (state_q == FEED);
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign accept_s = in_valid & in_ready;

    // Next-state logic: burst length tracking and the drain countdown
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        flush_cnt_d = flush_cnt_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == LEN_W'(0)) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = FEED;
                        remaining_d = len;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            FEED: begin
                if (accept_s) begin
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        if (SINGLE_LANE) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d     = FLUSH;
                            flush_cnt_d = FLUSH_INIT;
                        end
                    end else begin
                        state_d = FEED;
                    end
                end else begin
                    state_d = FEED;
                end
            end
            FLUSH: begin
                flush_cnt_d = flush_cnt_q - CNT_W'(1);
                // The edge that empties the countdown is the one that puts the
                // final element on lane N-1, so done and IDLE coincide with it.
                if (flush_cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = FLUSH;
                end
            end
            default: begin
                state_d     = IDLE;
                remaining_d = LEN_W'(0);
                flush_cnt_d = CNT_W'(0);
            end
        endcase
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            remaining_q <= LEN_W'(0);
            flush_cnt_q <= CNT_W'(0);
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            flush_cnt_q <= flush_cnt_d;
            done_q      <= done_d;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DATA_W-1:0] lane_in_s;

        assign lane_in_s = accept_s ? in_data[i*DATA_W +: DATA_W] : DATA_W'(ZERO_DATA);

        skew_delay_line #(
            .DEPTH  (i + 1),
            .DATA_W (DATA_W)
        ) u_delay (
            .clk     (clk),
            .clr_n   (reset),
            .data_i  (lane_in_s),
            .valid_i (accept_s),
            .data_o  (out_data[i*DATA_W +: DATA_W]),
            .valid_o (out_lane_valid[i])
        );
    end

endmodule

// File: tb/tb_systolic_input_skewer.sv
// Scoreboard bench for systolic_input_skewer: stimulus pushes expected lane
// elements and done pulses with their due edge; a negedge monitor checks them.
module tb_systolic_input_skewer;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int LW = 16;

    logic            clk = 1'b0;
    logic            reset, start, in_valid, in_ready, busy, done;
    logic [LW-1:0]   len;
    logic [N*DW-1:0] in_data, out_data;
    logic [N-1:0]    out_lane_valid;

    always #5 clk = ~clk;

    systolic_input_skewer #(.N(N), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .len            (len),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_data       (out_data),
        .out_lane_valid (out_lane_valid),
        .busy           (busy),
        .done           (done)
    );

    typedef struct {
        int              due;
        int              lane;
        logic [DW-1:0]   d;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   edge_n  = 0;
    bit   mon_en  = 1'b0;
    bit   m_feed  = 1'b0;
    bit   m_busy  = 1'b0;
    int   m_rem   = 0;
    int   m_end   = 0;
    int   errors  = 0;
    int   checks  = 0;

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @edge %0d: got=%h expected=%h", nm, edge_n, got, exp);
        end
    endtask

    // Reference behaviour: lane i of an accepted vector appears i edges later,
    // done follows the last accept by N-1 edges (or immediately for len==0).
    task automatic model_edge(input bit v, input logic [N*DW-1:0] d, input bit st,
                              input logic [LW-1:0] l, input bit rs);
        bit was_idle;
        edge_n++;
        was_idle = !m_busy;
        if (!rs) begin
            exp_q.delete();
            done_q.delete();
            m_feed = 1'b0;
            m_busy = 1'b0;
            m_rem  = 0;
            m_end  = 0;
        end else begin
            if (m_feed && v) begin
                for (int i = 0; i < N; i++) begin
                    exp_q.push_back('{due: edge_n + i, lane: i, d: d[i*DW +: DW]});
                end
                m_rem--;
                if (m_rem == 0) begin
                    m_feed = 1'b0;
                    m_end  = edge_n + N - 1;
                    done_q.push_back(m_end);
                end
            end else if (was_idle && st) begin
                if (l == '0) begin
                    done_q.push_back(edge_n);
                end else begin
                    m_feed = 1'b1;
                    m_rem  = int'(l);
                end
            end
            m_busy = m_feed || (edge_n < m_end);
        end
        mon_en = 1'b1;
    endtask

    task automatic drive(input bit v, input logic [N*DW-1:0] d, input bit st,
                         input logic [LW-1:0] l, input bit rs);
        in_valid = v;
        in_data  = d;
        start    = st;
        len      = l;
        reset    = rs;
        @(posedge clk);
        model_edge(v, d, st, l, rs);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    function automatic logic [N*DW-1:0] vecr(input real v);
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = $realtobits(v + i * 0.5);
        return r;
    endfunction

    function automatic logic [N*DW-1:0] rand_vec();
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = {$urandom, $urandom};
        return r;
    endfunction

    // Monitor: collect everything due at this edge and compare outputs
    always @(negedge clk) begin
        logic [N-1:0]    ev;
        logic [N*DW-1:0] ed;
        exp_t            keep[$];
        bit              edone;
        if (mon_en) begin
            ev = '0;
            ed = '0;
            keep.delete();
            foreach (exp_q[k]) begin
                if (exp_q[k].due == edge_n) begin
                    ev[exp_q[k].lane]              = 1'b1;
                    ed[exp_q[k].lane*DW +: DW]     = exp_q[k].d;
                end else begin
                    keep.push_back(exp_q[k]);
                end
            end
            exp_q = keep;
            edone = (done_q.size() > 0) && (done_q[0] == edge_n);
            if (edone) void'(done_q.pop_front());
            chk("in_ready", DW'(in_ready), DW'(m_feed));
            chk("busy", DW'(busy), DW'(m_busy));
            chk("done", DW'(done), DW'(edone));
            chk("lane_valid", DW'(out_lane_valid), DW'(ev));
            for (int i = 0; i < N; i++) begin
                chk($sformatf("lane%0d_data", i), out_data[i*DW +: DW], ed[i*DW +: DW]);
            end
        end
    end

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        len      = '0;
        in_valid = 1'b0;
        in_data  = '0;
        @(negedge clk);
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        drive(1'b1, rand_vec(), 1'b1, 16'd3, 1'b0);
        idle(2);

        // basic skew, len=3, in_valid held high
        drive(1'b0, '0, 1'b1, 16'd3, 1'b1);
        for (int v = 1; v <= 3; v++) drive(1'b1, vecr(real'(v)), 1'b0, '0, 1'b1);
        idle(6);

        // two bubbles between the vectors of a len=2 burst
        drive(1'b0, '0, 1'b1, 16'd2, 1'b1);
        drive(1'b1, vecr(1.0), 1'b0, '0, 1'b1);
        drive(1'b0, rand_vec(), 1'b0, '0, 1'b1);
        drive(1'b0, rand_vec(), 1'b0, '0, 1'b1);
        drive(1'b1, vecr(2.0), 1'b0, '0, 1'b1);
        idle(6);

        // zero length, valid data offered while idle
        drive(1'b0, '0, 1'b1, 16'd0, 1'b1);
        drive(1'b1, rand_vec(), 1'b0, '0, 1'b1);
        idle(3);

        // start while busy is ignored; trailing valids outside FEED ignored
        drive(1'b0, '0, 1'b1, 16'd2, 1'b1);
        drive(1'b1, vecr(1.0), 1'b1, 16'd5, 1'b1);
        drive(1'b1, vecr(2.0), 1'b0, '0, 1'b1);
        for (int k = 0; k < 5; k++) drive(1'b1, rand_vec(), 1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b1, 16'd1, 1'b1);
        drive(1'b1, vecr(7.0), 1'b0, '0, 1'b1);
        idle(5);

        // reset after the 2nd of 4 vectors, then a fresh len=1 burst
        drive(1'b0, '0, 1'b1, 16'd4, 1'b1);
        drive(1'b1, vecr(3.0), 1'b0, '0, 1'b1);
        drive(1'b1, vecr(4.0), 1'b0, '0, 1'b1);
        drive(1'b1, vecr(5.0), 1'b0, '0, 1'b0);
        idle(3);
        drive(1'b0, '0, 1'b1, 16'd1, 1'b1);
        drive(1'b1, vecr(9.0), 1'b0, '0, 1'b1);
        idle(5);

        // randomized bursts with bubbles, spurious starts and occasional reset
        for (int r = 0; r < 30; r++) begin
            drive(1'b0, '0, 1'b1, LW'($urandom_range(0, 6)), 1'b1);
            for (int g = 0; g < 60 && m_busy; g++) begin
                drive($urandom_range(0, 3) != 0, rand_vec(), $urandom_range(0, 7) == 0,
                      LW'($urandom_range(1, 9)), $urandom_range(0, 40) != 0);
            end
            idle($urandom_range(0, 2));
        end

        idle(8);
        chk("lanes_drained", DW'(exp_q.size()), DW'(0));
        chk("done_drained", DW'(done_q.size()), DW'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
